fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/fetch_decode_queue.sv | 132 +++++++++++++
 tb/tb_fetch_decode_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular FIFO with exception lock.
// Optional empty-queue bypass compiled in with FETCH_QUEUE_BYPASS_EN.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   in_valid, in_pc,        fetch side: instruction presented this cycle
//   in_instruction,
//   in_exception_vector     fetch exception code, 0 = none
//   in_flush                discard all contents on next edge
//   in_decode_ready         decode consumes head when out_valid
//   out_full                queue cannot accept (full or locked)
//   out_valid, out_pc,      head entry, zero when not valid
//   out_instruction,
//   out_exception_vector
//   out_count               occupied entries
module fetch_decode_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instruction,
  input  logic [2:0]               in_exception_vector,
  input  logic                     in_flush,
  input  logic                     in_decode_ready,
  output logic                     out_full,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instruction,
  output logic [2:0]               out_exception_vector,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lock_q, lock_d;

  logic [31:0] pc_mem_q  [DEPTH];
  logic [31:0] ins_mem_q [DEPTH];
  logic [2:0]  exc_mem_q [DEPTH];

  logic empty;
  logic push;
  logic pop;
  logic byp;
  logic wr_en;

  assign empty    = (count_q == '0);
  assign out_full = (count_q == CNT_W'(DEPTH)) || lock_q;
  assign out_count = count_q;

  // push: entry accepted from fetch (stored or bypassed)
  assign push = in_valid && !out_full && !in_flush;
  assign pop  = !empty && in_decode_ready && !in_flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  // empty queue forwards the fetch entry straight to decode
  assign byp = empty && push;
`else
  assign byp = 1'b0;
`endif

  // a bypassed entry that decode takes never touches storage
  assign wr_en = push && !(byp && in_decode_ready);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    lock_d   = lock_q;
    if (in_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      lock_d   = 1'b0;
    end else begin
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en)
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      if (push && (in_exception_vector != 3'd0))
        lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      lock_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      lock_q   <= lock_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_q[wr_ptr_q]  <= in_pc;
      ins_mem_q[wr_ptr_q] <= in_instruction;
      exc_mem_q[wr_ptr_q] <= in_exception_vector;
    end
  end

  always_comb begin
    out_valid            = 1'b0;
    out_pc               = '0;
    out_instruction      = '0;
    out_exception_vector = '0;
    if (!empty) begin
      out_valid            = 1'b1;
      out_pc               = pc_mem_q[rd_ptr_q];
      out_instruction      = ins_mem_q[rd_ptr_q];
      out_exception_vector = exc_mem_q[rd_ptr_q];
    end else if (byp) begin
      out_valid            = 1'b1;
      out_pc               = in_pc;
      out_instruction      = in_instruction;
      out_exception_vector = in_exception_vector;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instruction;
  logic [2:0]  in_exception_vector;
  logic        in_flush;
  logic        in_decode_ready;
  logic        out_full;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [2:0]  out_exception_vector;
  logic [$clog2(DEPTH):0] out_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [2:0]  ex;
  } ent_t;

  ent_t mq[$];
  bit   lock;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_pc                (in_pc),
    .in_instruction       (in_instruction),
    .in_exception_vector  (in_exception_vector),
    .in_flush             (in_flush),
    .in_decode_ready      (in_decode_ready),
    .out_full             (out_full),
    .out_valid            (out_valid),
    .out_pc               (out_pc),
    .out_instruction      (out_instruction),
    .out_exception_vector (out_exception_vector),
    .out_count            (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc,
                              input logic [2:0] ex);
    ent_t e;
    e.pc  = pc;
    e.ins = (pc * 32'h9E37_79B1) ^ 32'h0000_1357;
    e.ex  = ex;
    return e;
  endfunction

  task automatic idle();
    in_valid            = 1'b0;
    in_pc               = '0;
    in_instruction      = '0;
    in_exception_vector = '0;
    in_flush            = 1'b0;
    in_decode_ready     = 1'b0;
  endtask

  // one clock: drive, check at negedge against model, advance model
  task automatic step(input bit v, input logic [31:0] pc,
                      input logic [2:0] ex, input bit fl,
                      input bit rdy);
    ent_t e;
    ent_t h;
    bit   full;
    bit   byp;
    bit   vld;
    e = mk(pc, ex);
    in_valid            = v;
    in_pc               = e.pc;
    in_instruction      = e.ins;
    in_exception_vector = e.ex;
    in_flush            = fl;
    in_decode_ready     = rdy;
    @(negedge clk);
    full = (mq.size() == DEPTH) || lock;
    byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (mq.size() == 0) && v && !lock && !fl;
`endif
    vld = (mq.size() != 0) || byp;
    if (mq.size() != 0)
      h = mq[0];
    else if (byp)
      h = e;
    else
      h = '{pc: 32'd0, ins: 32'd0, ex: 3'd0};
    check("valid", out_valid, vld);
    check("full", out_full, full);
    check("count", 32'(out_count), 32'(mq.size()));
    check("pc", out_pc, h.pc);
    check("ins", out_instruction, h.ins);
    check("exc", 32'(out_exception_vector), 32'(h.ex));
    @(posedge clk);
    if (fl) begin
      mq.delete();
      lock = 1'b0;
    end else begin
      if (vld && rdy && !byp)
        void'(mq.pop_front());
      if (v && !full) begin
        if (!(byp && rdy))
          mq.push_back(e);
        if (ex != 3'd0)
          lock = 1'b1;
      end
    end
    #1;
    idle();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
  endtask

  initial begin
    idle();
    lock  = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_full", out_full, 1'b0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_ins", out_instruction, 32'd0);
    check("rst_exc", 32'(out_exception_vector), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // three pushes held, then drained in order
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h1000 + 32'(4 * i), 3'd0, 1'b0, 1'b0);
    check("hold_count", 32'(out_count), 32'd3);
    check("hold_pc", out_pc, 32'h1000);
    drain(3);
    check("drained_valid", out_valid, 1'b0);

    // fill to full, fifth dropped, pop with push while full
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h1100 + 32'(4 * i), 3'd0, 1'b0, 1'b0);
    check("full_flag", out_full, 1'b1);
    check("full_count", 32'(out_count), 32'(DEPTH));
    step(1'b1, 32'h1200, 3'd0, 1'b0, 1'b1);
    check("pop_full_count", 32'(out_count), 32'(DEPTH - 1));
    step(1'b1, 32'h1204, 3'd0, 1'b0, 1'b0);
    check("refill_count", 32'(out_count), 32'(DEPTH));
    drain(5);

    // flush beats same-cycle push and pop
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h1300 + 32'(4 * i), 3'd0, 1'b0, 1'b0);
    step(1'b1, 32'h1400, 3'd0, 1'b1, 1'b1);
    check("flush_count", 32'(out_count), 32'd0);
    check("flush_valid", out_valid, 1'b0);
    step(1'b1, 32'h2000, 3'd0, 1'b0, 1'b0);
    check("post_flush_pc", out_pc, 32'h2000);
    drain(2);

    // exception lock
    step(1'b1, 32'h1000, 3'd0, 1'b0, 1'b0);
    step(1'b1, 32'h1004, 3'd1, 1'b0, 1'b0);
    check("lock_full", out_full, 1'b1);
    step(1'b1, 32'h1008, 3'd0, 1'b0, 1'b0);
    check("lock_count", 32'(out_count), 32'd2);
    drain(3);
    check("lock_held", out_full, 1'b1);
    step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    check("lock_cleared", out_full, 1'b0);

    // pointer wrap with push/pop pairs
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h4000 + 32'(4 * i), 3'd0, 1'b0, 1'b1);
      check("wrap_le1", 32'(out_count <= 1), 32'd1);
    end
    drain(2);

    // empty-queue push with decode ready
    step(1'b1, 32'h3000, 3'd0, 1'b0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_count", 32'(out_count), 32'd0);
    check("byp_valid_after", out_valid, 1'b0);
`else
    check("nobyp_valid", out_valid, 1'b1);
    check("nobyp_pc", out_pc, 32'h3000);
`endif
    drain(2);

    // asynchronous reset mid-operation
    step(1'b1, 32'h5000, 3'd0, 1'b0, 1'b0);
    step(1'b1, 32'h5004, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_count", 32'(out_count), 32'd0);
    check("arst_pc", out_pc, 32'd0);
    mq.delete();
    lock  = 1'b0;
    reset = 1'b0;
    #1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit          v;
      bit          fl;
      bit          rdy;
      logic [2:0]  ex;
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      ex  = ($urandom_range(0, 11) == 0) ?
            3'($urandom_range(1, 7)) : 3'd0;
      step(v, {$urandom} & 32'hFFFF_FFFC, ex, fl, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
